// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the Tuse/Tnew hazard scoreboard.
// An empty pipeline slot (bubble) is all-zero: a3 = 0 never matches a source.
package hazard_scoreboard_pkg;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  localparam int BUBBLE_A3   = 0;
  localparam int BUBBLE_TNEW = 0;

  // Forward select: 0 = register file, k = forward from entry k-1.
  localparam int FWD_RF = 0;

  function automatic int fwd_code(input int entry_idx);
    return entry_idx + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Youngest-first match of one D-stage source against the in-flight destinations.
// Purely combinational; an unused source (Tuse all-ones) or $0 never matches.
module hazard_scoreboard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSTAGE = 3,
  parameter int TW     = 2,
  parameter int SW     = 2
) (
  input  logic [NSTAGE-1:0][REG_AW-1:0] ent_a3_i,
  input  logic [NSTAGE-1:0][TW-1:0]     ent_tnew_i,
  input  logic [REG_AW-1:0]             src_i,
  input  logic [TW-1:0]                 tuse_i,
  output logic                          hz_o,
  output logic [SW-1:0]                 fwd_sel_o
);

  localparam logic [TW-1:0] TUSE_NONE = '1;

  logic          hit;
  logic [TW-1:0] hit_tnew;
  logic [SW-1:0] hit_sel;

  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    hit_sel  = SW'(FWD_RF);
    // Walk oldest to youngest so the youngest match is the one left standing.
    if (src_i != '0 && tuse_i != TUSE_NONE) begin
      for (int i = NSTAGE - 1; i >= 0; i--) begin
        if (ent_a3_i[i] == src_i) begin
          hit      = 1'b1;
          hit_tnew = ent_tnew_i[i];
          hit_sel  = SW'(fwd_code(i));
        end
      end
    end
    hz_o      = hit && (hit_tnew > tuse_i);
    fwd_sel_o = (hit && hit_tnew == '0) ? hit_sel : SW'(FWD_RF);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew stall/forward controller beside the D stage, with HI/LO busy counter,
// flush of E..W and a saturating stall-cycle counter. Hazard outputs are combinational.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NSTAGE   = 3,
  parameter int TW       = 2,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CW       = 4,
  parameter int PW       = 32,
  parameter int SW       = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [SW-1:0]     fwd_rs_sel,
  output logic [SW-1:0]     fwd_rt_sel,
  output logic              md_busy,
  output logic [PW-1:0]     stall_cnt
);

  localparam logic [TW-1:0] TNEW_MAX = TW'(NSTAGE - 1);

  logic [NSTAGE-1:0][REG_AW-1:0] a3_q, a3_d;
  logic [NSTAGE-1:0][TW-1:0]     tnew_q, tnew_d;
  logic [CW-1:0]                 busy_q, busy_d;
  logic [PW-1:0]                 stall_cnt_q, stall_cnt_d;

  logic          hz_rs, hz_rt, hz_md;
  logic          accept;
  logic [TW-1:0] tnew_clamped;

  hazard_scoreboard_src_match #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .TW(TW), .SW(SW)) u_match_rs (
    .ent_a3_i   (a3_q),
    .ent_tnew_i (tnew_q),
    .src_i      (d_rs),
    .tuse_i     (d_tuse_rs),
    .hz_o       (hz_rs),
    .fwd_sel_o  (fwd_rs_sel)
  );

  hazard_scoreboard_src_match #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .TW(TW), .SW(SW)) u_match_rt (
    .ent_a3_i   (a3_q),
    .ent_tnew_i (tnew_q),
    .src_i      (d_rt),
    .tuse_i     (d_tuse_rt),
    .hz_o       (hz_rt),
    .fwd_sel_o  (fwd_rt_sel)
  );

  assign hz_md        = d_md_use && (busy_q != '0);
  assign stall        = (hz_rs || hz_rt || hz_md) && !flush;
  assign accept       = !stall && !flush;
  assign tnew_clamped = (d_tnew > TNEW_MAX) ? TNEW_MAX : d_tnew;
  assign md_busy      = (busy_q != '0);
  assign stall_cnt    = stall_cnt_q;

  always_comb begin
    a3_d   = '0;
    tnew_d = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      a3_d[i]   = a3_q[i-1];
      tnew_d[i] = (tnew_q[i-1] != '0) ? tnew_q[i-1] - TW'(1) : '0;
    end
    // Flush empties E..W: entries shifting out of E are dropped too.
    if (flush) begin
      a3_d   = '0;
      tnew_d = '0;
    end
    if (accept) begin
      a3_d[0]   = d_a3;
      tnew_d[0] = tnew_clamped;
    end else begin
      a3_d[0]   = REG_AW'(BUBBLE_A3);
      tnew_d[0] = TW'(BUBBLE_TNEW);
    end

    busy_d = busy_q;
    if (d_md_start && accept) begin
      busy_d = d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (busy_q != '0) begin
      busy_d = busy_q - CW'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_q        <= '0;
      tnew_q      <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      a3_q        <= a3_d;
      tnew_q      <= tnew_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a behavioural model.
module tb_hazard_scoreboard;

  localparam int NS = 3;
  localparam int ML = 5;
  localparam int DL = 10;
  localparam int PW = 4;
  localparam int CNT_MAX = (1 << PW) - 1;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [PW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.PW(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  // Model: pipeline slots E..W as plain integer arrays, counters as integers.
  int m_a3 [NS];
  int m_tn [NS];
  int m_busy, m_cnt;
  bit m_valid;

  int n_checks, n_err;
  int o_stall, o_frs, o_frt, o_busy, o_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void src_rule(input int s, input int tuse, output bit hz, output int fwd);
    hz  = 1'b0;
    fwd = 0;
    if (s == 0 || tuse == 3) return;
    for (int i = 0; i < NS; i++) begin
      if (m_a3[i] == s) begin
        hz  = (m_tn[i] > tuse);
        fwd = (m_tn[i] == 0) ? i + 1 : 0;
        return;
      end
    end
  endfunction

  // One clock: drive inputs, compare at negedge, advance the model at posedge.
  task automatic step(input int rs, input int rt, input int tur, input int tut,
                      input int a3, input int tn, input int mds, input int mdd,
                      input int mdu, input int fl, input int rst);
    bit hzr, hzt, hzm, est;
    int fr, ft, ntn;
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut);
    d_a3 = 5'(a3); d_tnew = 2'(tn); d_md_start = 1'(mds); d_md_div = 1'(mdd);
    d_md_use = 1'(mdu); flush = 1'(fl); reset = 1'(rst);
    @(negedge clk);
    src_rule(rs, tur, hzr, fr);
    src_rule(rt, tut, hzt, ft);
    hzm = (mdu != 0) && (m_busy > 0);
    est = (hzr || hzt || hzm) && (fl == 0);
    o_stall = int'(stall); o_frs = int'(fwd_rs_sel); o_frt = int'(fwd_rt_sel);
    o_busy = int'(md_busy); o_cnt = int'(stall_cnt);
    if (m_valid) begin
      chk("stall", o_stall, int'(est));
      chk("fwd_rs_sel", o_frs, fr);
      chk("fwd_rt_sel", o_frt, ft);
      chk("md_busy", o_busy, int'(m_busy > 0));
      chk("stall_cnt", o_cnt, m_cnt);
    end
    @(posedge clk);
    if (rst != 0) begin
      foreach (m_a3[i]) begin m_a3[i] = 0; m_tn[i] = 0; end
      m_busy = 0; m_cnt = 0; m_valid = 1'b1;
    end else begin
      for (int i = NS - 1; i >= 1; i--) begin
        m_a3[i] = (fl != 0) ? 0 : m_a3[i-1];
        m_tn[i] = (fl != 0) ? 0 : ((m_tn[i-1] > 0) ? m_tn[i-1] - 1 : 0);
      end
      ntn = (tn > NS - 1) ? NS - 1 : tn;
      m_a3[0] = (!est && fl == 0) ? a3 : 0;
      m_tn[0] = (!est && fl == 0) ? ntn : 0;
      if (mds != 0 && !est && fl == 0) m_busy = (mdd != 0) ? DL : ML;
      else if (m_busy > 0) m_busy--;
      if (est && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_err = 0; m_valid = 1'b0;
    m_busy = 0; m_cnt = 0;
    foreach (m_a3[i]) begin m_a3[i] = 0; m_tn[i] = 0; end
    #1;

    // Reset state
    do_reset();
    idle();
    chk("rst_stall", o_stall, 0);
    chk("rst_fwd_rs", o_frs, 0);
    chk("rst_md_busy", o_busy, 0);
    chk("rst_stall_cnt", o_cnt, 0);

    // lw $2 (tnew=2), then calR reading $2 with tuse=1
    step(0, 0, 3, 3, 2, 2, 0, 0, 0, 0, 0);
    step(2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("lw_use_stall", o_stall, 1);
    step(2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("lw_use_release", o_stall, 0);
    chk("lw_use_cnt", o_cnt, 1);
    step(2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("lw_fwd_from_w", o_frs, 3);

    // ori $3 (tnew=1), then beq on rt=$3 with tuse=0; then $0 never hazards
    do_reset();
    step(0, 0, 3, 3, 3, 1, 0, 0, 0, 0, 0);
    step(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_stall", o_stall, 1);
    step(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_release", o_stall, 0);
    chk("beq_fwd_rt", o_frt, 2);
    step(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_reg_stall", o_stall, 0);
    chk("zero_reg_fwd", o_frs, 0);

    // addu $4 then lw $4: the younger lw shadows the older ready value
    do_reset();
    step(0, 0, 3, 3, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 3, 4, 2, 0, 0, 0, 0, 0);
    step(4, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("youngest_stall", o_stall, 1);
    chk("youngest_fwd", o_frs, 0);

    // Oversized tnew is clamped to NSTAGE-1
    do_reset();
    step(0, 0, 3, 3, 6, 3, 0, 0, 0, 0, 0);
    step(6, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("clamp_stall", o_stall, 0);

    // mult then mflo: exactly MULT_LAT stall cycles; div gives DIV_LAT
    for (int d = 0; d < 2; d++) begin
      do_reset();
      step(0, 0, 3, 3, 0, 0, 1, d, 1, 0, 0);
      for (int k = 0; k <= ((d != 0) ? DL : ML); k++) begin
        step(0, 0, 3, 3, 2, 0, 0, 0, 1, 0, 0);
        chk((d != 0) ? "div_stall" : "mult_stall", o_stall, int'(k < ((d != 0) ? DL : ML)));
        chk("md_busy_win", o_busy, int'(k < ((d != 0) ? DL : ML)));
      end
    end

    // Flush beats a pending hazard and empties the pipe
    do_reset();
    step(0, 0, 3, 3, 5, 2, 0, 0, 0, 0, 0);
    step(5, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_stall", o_stall, 0);
    step(5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("post_flush_stall", o_stall, 0);
    chk("post_flush_fwd", o_frs, 0);

    // Back-to-back divs stall more than 2^PW cycles; counter saturates; reset clears
    do_reset();
    for (int k = 0; k < 25; k++) step(0, 0, 3, 3, 0, 0, 1, 1, 1, 0, 0);
    chk("cnt_saturate", o_cnt, CNT_MAX);
    step(0, 0, 3, 3, 0, 0, 1, 1, 1, 0, 1);
    idle();
    chk("mid_rst_stall", o_stall, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_cnt", o_cnt, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           int'($urandom_range(0, 7) == 0), $urandom_range(0, 1),
           int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
